mouse_packet_tracker: RTL and testbench
=======================================

Name: mouse_packet_tracker

Overview:
- Sits directly upstream of the mouse interface top-level's cursor/click outputs.
- Consumes the byte stream from the PS/2 receiver and assembles standard 3-byte PS/2 mouse packets.
- Integrates the signed X/Y deltas into a clamped screen cursor position (640x480) and derives button levels and single-cycle left/right click pulses.
- Its outputs feed block-coordinate mapping and the game logic.

Parameters:
- X_MAX, 639, largest legal mouse_x.
- Y_MAX, 479, largest legal mouse_y.
- X_INIT, 320, mouse_x after reset.
- Y_INIT, 240, mouse_y after reset.
- TIMEOUT_CYC, 2000000, idle cycles mid-packet before resync (20 ms at 100 MHz).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- byte_in  input  8  received PS/2 byte.
- byte_valid  input  1  one-cycle strobe; byte_in is valid this cycle.
- mouse_x  output  10  cursor X, 0..X_MAX.
- mouse_y  output  9  cursor Y, 0..Y_MAX; 0 is the top row.
- l_down  output  1  left button level from last good packet.
- r_down  output  1  right button level from last good packet.
- l_click  output  1  one-cycle pulse on a left-button 0->1 transition.
- r_click  output  1  one-cycle pulse on a right-button 0->1 transition.
- packet_done  output  1  one-cycle pulse when a packet is applied.
- sync_err  output  1  one-cycle pulse when a byte is discarded or a timeout resync occurs.

Behaviour:
Reset:
- On rst low, asynchronously: state=WAIT_B0, mouse_x=X_INIT, mouse_y=Y_INIT.
- l_down, r_down, l_click, r_click, packet_done and sync_err = 0; timeout counter = 0; byte registers = 0.
- Reset mid-packet discards the partial packet.

FSM states WAIT_B0, WAIT_B1, WAIT_B2, APPLY:
- WAIT_B0: on byte_valid, if byte_in[3]==1, store as b0 and go to WAIT_B1. Otherwise discard, pulse sync_err, and stay in WAIT_B0.
- WAIT_B1: on byte_valid, store b1 and go to WAIT_B2.
- WAIT_B2: on byte_valid, store b2 and go to APPLY.
- APPLY: lasts exactly one cycle, then returns to WAIT_B0. Any byte_valid during APPLY is ignored (the upstream PS/2 byte rate makes this impossible in practice).

Timeout:
- The counter clears on every byte_valid and whenever the state is WAIT_B0.
- It increments every cycle in WAIT_B1/WAIT_B2.
- On reaching TIMEOUT_CYC-1: go to WAIT_B0, pulse sync_err, clear the counter.
- If byte_valid arrives in the same cycle as the timeout expiry, the byte wins and the timeout does not fire.

APPLY cycle (registered outputs update at the end of the APPLY cycle):
- dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
- If b0[6] (X overflow) or b0[7] (Y overflow) is set, both deltas are treated as 0; buttons are still updated.
- Position update uses 11-bit signed arithmetic:
  - nx = mouse_x + dx
  - ny = mouse_y - dy (PS/2 Y is positive-up)
- Clamping: below 0 becomes 0; nx above X_MAX becomes X_MAX; ny above Y_MAX becomes Y_MAX.
- l_down <= b0[0]; r_down <= b0[1].
- l_click = 1 iff b0[0]==1 and the previous l_down==0; r_click likewise for the right button.
- packet_done = 1.
- All pulses are high for exactly one cycle, the cycle after APPLY. They are 0 otherwise.

Latency:
- Positions, button levels and pulses become visible 2 cycles after the byte_valid of byte 3 (the APPLY cycle, then the registered output).
- Middle button (b0[2]) is ignored.

Test Plan:
- Reset, then packet 0x08, 0x0A, 0x05 -> mouse_x=330, mouse_y=235, packet_done one pulse, no click.
- From reset, packet 0x09, 0x00, 0x00 -> l_down=1, l_click high exactly one cycle. Repeat the same packet -> no second l_click. Then 0x08, 0x00, 0x00 -> l_down=0.
- From reset, packet 0x18, 0x00, 0x00 (dx=-256), sent twice -> mouse_x=64, then 0. Then 0x08, 0xFF, 0x00 sent three times -> mouse_x=639 (clamped). Packet 0x28, 0x00, 0x00 (dy=-256), sent twice -> mouse_y=479.
- Byte 0x00 as first byte -> sync_err pulse and state stays WAIT_B0. Then a valid 3-byte packet 0x08, 0x01, 0x01 -> applied normally (x=321, y=239).
- Send 0x08, 0x10 then idle TIMEOUT_CYC cycles (use TIMEOUT_CYC=100 in sim) -> sync_err pulse. Next packet 0x09, 0x00, 0x00 -> applied as a fresh packet with l_click; position unchanged.
- Packet 0x49, 0x7F, 0x7F (X overflow) -> position unchanged, l_down=1, l_click pulse. Also assert rst mid-packet -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/mouse_packet_tracker.sv
// ============================================================================
// mouse_packet_tracker
// Assembles 3-byte PS/2 mouse packets and integrates them into a clamped
// 640x480 cursor position with button levels and click pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mouse_packet_tracker #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [9:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic       l_down,
    output logic       r_down,
    output logic       l_click,
    output logic       r_click,
    output logic       packet_done,
    output logic       sync_err
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        APPLY   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          l_down_q, l_down_d, r_down_q, r_down_d;
    logic          l_click_q, l_click_d, r_click_q, r_click_d;
    logic          done_q, done_d, err_q, err_d;

    // Overflowed packets still carry valid buttons, so only motion is dropped.
    logic               ovf;
    logic signed [10:0] dx, dy, nx, ny;
    assign ovf = b0_q[6] | b0_q[7];
    assign dx  = ovf ? '0 : {{2{b0_q[4]}}, b0_q[4], b1_q};
    assign dy  = ovf ? '0 : {{2{b0_q[5]}}, b0_q[5], b2_q};
    assign nx  = $signed({1'b0, x_q}) + dx;
    assign ny  = $signed({2'b00, y_q}) - dy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        x_d       = x_q;
        y_d       = y_q;
        l_down_d  = l_down_q;
        r_down_d  = r_down_q;
        l_click_d = 1'b0;
        r_click_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            WAIT_B0: begin
                cnt_d = '0;
                if (byte_valid) begin
                    if (byte_in[3]) begin
                        b0_d    = byte_in;
                        state_d = WAIT_B1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_B1, WAIT_B2: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (byte_valid) begin
                    cnt_d = '0;
                    if (state_q == WAIT_B1) begin
                        b1_d    = byte_in;
                        state_d = WAIT_B2;
                    end else begin
                        b2_d    = byte_in;
                        state_d = APPLY;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = WAIT_B0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APPLY: begin
                state_d = WAIT_B0;
                cnt_d   = '0;
                if (nx < 0)             x_d = '0;
                else if (nx > X_MAX_S)  x_d = 10'(X_MAX);
                else                    x_d = nx[9:0];
                if (ny < 0)             y_d = '0;
                else if (ny > Y_MAX_S)  y_d = 9'(Y_MAX);
                else                    y_d = ny[8:0];
                l_down_d  = b0_q[0];
                r_down_d  = b0_q[1];
                l_click_d = b0_q[0] & ~l_down_q;
                r_click_d = b0_q[1] & ~r_down_q;
                done_d    = 1'b1;
            end
            default: state_d = WAIT_B0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WAIT_B0;
            cnt_q     <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            x_q       <= 10'(X_INIT);
            y_q       <= 9'(Y_INIT);
            l_down_q  <= 1'b0;
            r_down_q  <= 1'b0;
            l_click_q <= 1'b0;
            r_click_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            x_q       <= x_d;
            y_q       <= y_d;
            l_down_q  <= l_down_d;
            r_down_q  <= r_down_d;
            l_click_q <= l_click_d;
            r_click_q <= r_click_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign mouse_x     = x_q;
    assign mouse_y     = y_q;
    assign l_down      = l_down_q;
    assign r_down      = r_down_q;
    assign l_click     = l_click_q;
    assign r_click     = r_click_q;
    assign packet_done = done_q;
    assign sync_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_packet_tracker.sv
// ============================================================================
// tb_mouse_packet_tracker
// Directed, table-driven bench for the PS/2 mouse packet tracker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mouse_packet_tracker;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [9:0] mouse_x;
    logic [8:0] mouse_y;
    logic       l_down, r_down, l_click, r_click, packet_done, sync_err;

    int checks = 0;
    int errors = 0;

    mouse_packet_tracker #(
        .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .l_down(l_down), .r_down(r_down),
        .l_click(l_click), .r_click(r_click), .packet_done(packet_done),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         x, y;
        logic       l, r, lc, rc;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Returns on the falling edge just after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        check("done_early", int'(packet_done), 0);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{8'h08, 8'h0A, 8'h05, 330, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h09, 8'h00, 8'h00, 330, 235, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'h09, 8'h00, 8'h00, 330, 235, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h08, 8'h00, 8'h00, 330, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h0A, 8'h00, 8'h00, 330, 235, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{8'h18, 8'h00, 8'h00,  74, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h18, 8'h00, 8'h00,   0, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h08, 8'hFF, 8'h00, 255, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h08, 8'hFF, 8'h00, 510, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h08, 8'hFF, 8'h00, 639, 235, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h28, 8'h00, 8'h00, 639, 479, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{8'h38, 8'h01, 8'h01, 384, 479, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h08, 8'h00, 8'hFF, 384, 224, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'h08, 8'h00, 8'h80, 384,  96, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'h08, 8'h00, 8'h80, 384,   0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{8'h49, 8'h7F, 8'h7F, 384,   0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{8'h8B, 8'h05, 8'h05, 384,   0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{8'h0C, 8'h03, 8'h00, 387,   0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values
        do_reset();
        check("rst_x", int'(mouse_x), 320);
        check("rst_y", int'(mouse_y), 240);
        check("rst_btn", int'({l_down, r_down, l_click, r_click}), 0);
        check("rst_pulse", int'({packet_done, sync_err}), 0);

        // Bad first byte is discarded, then a good packet applies normally
        send_byte(8'h00);
        check("bad_b0_err", int'(sync_err), 1);
        @(negedge clk);
        check("bad_b0_err_off", int'(sync_err), 0);
        send_pkt(8'h08, 8'h01, 8'h01);
        check("resync_x", int'(mouse_x), 321);
        check("resync_y", int'(mouse_y), 239);
        check("resync_done", int'(packet_done), 1);

        // Chained packet table
        do_reset();
        foreach (vecs[i]) begin
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
            check($sformatf("v%0d_x", i), int'(mouse_x), vecs[i].x);
            check($sformatf("v%0d_y", i), int'(mouse_y), vecs[i].y);
            check($sformatf("v%0d_l", i), int'(l_down), int'(vecs[i].l));
            check($sformatf("v%0d_r", i), int'(r_down), int'(vecs[i].r));
            check($sformatf("v%0d_lc", i), int'(l_click), int'(vecs[i].lc));
            check($sformatf("v%0d_rc", i), int'(r_click), int'(vecs[i].rc));
            check($sformatf("v%0d_done", i), int'(packet_done), 1);
            check($sformatf("v%0d_err", i), int'(sync_err), 0);
            @(negedge clk);
            check($sformatf("v%0d_pulses_off", i),
                  int'({l_click, r_click, packet_done}), 0);
        end

        // Reset mid-packet: outputs return immediately, partial packet lost
        send_byte(8'h09);
        send_byte(8'h0A);
        rst = 1'b0;
        #1;
        check("midrst_x", int'(mouse_x), 320);
        check("midrst_y", int'(mouse_y), 240);
        check("midrst_btn", int'({l_down, r_down, l_click, r_click}), 0);
        @(negedge clk);
        rst = 1'b1;
        send_pkt(8'h18, 8'h00, 8'h00);
        check("left_x1", int'(mouse_x), 64);
        send_pkt(8'h18, 8'h00, 8'h00);
        check("left_x0", int'(mouse_x), 0);

        // Mid-packet timeout resync
        do_reset();
        send_byte(8'h08);
        send_byte(8'h10);
        begin
            logic early = 1'b0;
            logic seen  = 1'b0;
            for (int i = 0; i < TO / 2; i++) begin
                @(negedge clk);
                early |= sync_err;
            end
            check("timeout_not_early", int'(early), 0);
            for (int i = 0; i < 2 * TO && !seen; i++) begin
                @(negedge clk);
                seen = sync_err;
            end
            check("timeout_err", int'(seen), 1);
        end
        send_pkt(8'h09, 8'h00, 8'h00);
        check("to_x", int'(mouse_x), 320);
        check("to_y", int'(mouse_y), 240);
        check("to_lclick", int'(l_click), 1);
        check("to_done", int'(packet_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
